// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and state encoding for the load/store unit
// Contents:
//   DEF_MEM_WORDS, DEF_AW : default data-memory geometry (words, word-index width)
//   F3_*                  : RISC-V funct3 codes for loads/stores
//   lsu_state_t           : controller FSM states
package lsu_pkg;

  localparam int DEF_MEM_WORDS = 256;
  localparam int DEF_AW        = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LX,
    S_MRG,
    S_WR,
    S_ERR
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - byte/half lane extraction and sub-word merge
// Ports:
//   word     in  32  memory word (little-endian lanes, byte k = bits 8k+7:8k)
//   off      in  2   byte offset within the word
//   funct3   in  3   access size/sign code
//   sdata    in  32  store data (low byte/half used for SB/SH)
//   load_val out 32  sign- or zero-extended load value
//   merged   out 32  word with the addressed lane replaced by store data
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] sdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b        = word[{off, 3'b000} +: 8];
    // Halfword accesses are aligned, so only off[1] picks the lane.
    h        = off[1] ? word[31:16] : word[15:0];
    load_val = word;
    merged   = word;
    case (funct3)
      F3_B:  load_val = {{24{b[7]}}, b};
      F3_H:  load_val = {{16{h[15]}}, h};
      F3_BU: load_val = {24'h0, b};
      F3_HU: load_val = {16'h0, h};
      default: load_val = word;
    endcase
    case (funct3)
      F3_B: merged[{off, 3'b000} +: 8] = sdata[7:0];
      F3_H: begin
        if (off[1]) merged[31:16] = sdata[15:0];
        else        merged[15:0]  = sdata[15:0];
      end
      default: merged = sdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - byte-addressed load/store initiator for a word-only data memory
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready      core request handshake
//   req_we, req_funct3       store flag and RISC-V access code
//   req_addr, req_wdata      byte address and store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data / error flag, held until next response
//   mem_addr, mem_wdata      word index and write word to memory
//   mem_we                   memory write enable
//   mem_rdata                memory read data, one cycle after mem_addr
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int AW        = DEF_AW
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  lsu_state_t state_q, state_d;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mrg_q;

  logic          acc;
  logic          req_err;
  logic [31:0]   word_addr;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  assign req_ready = (state_q == S_IDLE) && !RST;
  assign acc       = req_valid && req_ready;
  assign word_addr = {{(32-AW){1'b0}}, addr_q[AW+1:2]};

  // Request legality, evaluated on the raw inputs so the error path never
  // issues a memory cycle.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      case (req_funct3)
        F3_B:    req_err = 1'b0;
        F3_H:    req_err = req_addr[0];
        F3_W:    req_err = |req_addr[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        F3_B, F3_BU: req_err = 1'b0;
        F3_H, F3_HU: req_err = req_addr[0];
        F3_W:        req_err = |req_addr[1:0];
        default:     req_err = 1'b1;
      endcase
    end
    if (|req_addr[31:AW+2])                        req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) req_err = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (req_err)                              state_d = S_ERR;
          else if (!req_we || req_funct3 != F3_W)   state_d = S_RD;
          else                                      state_d = S_WR;
        end
      end
      S_RD: begin
        mem_addr = word_addr;
        state_d  = we_q ? S_MRG : S_LX;
      end
      S_LX:  state_d = S_IDLE;
      S_MRG: state_d = S_WR;
      S_WR: begin
        mem_addr  = word_addr;
        mem_wdata = (f3_q == F3_W) ? wdata_q : mrg_q;
        mem_we    = !RST;
        state_d   = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  lsu_byte_lane u_lane (
    .word     (mem_rdata),
    .off      (addr_q[1:0]),
    .funct3   (f3_q),
    .sdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q       <= 1'b0;
      f3_q       <= 3'h0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      mrg_q      <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (acc) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW+1:0];
        wdata_q <= req_wdata;
      end
      case (state_q)
        S_LX: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_val;
          resp_err   <= 1'b0;
        end
        S_MRG: mrg_q <= merged;
        S_WR: begin
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
        end
        S_ERR: begin
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
          resp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int nvec  = 0;
  int nfail = 0;

  logic [31:0] mem [256];
  int          wcnt = 0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] last_wd = 32'h0;

  always #5 CLK = ~CLK;

  lsu_mem_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // Word-only memory with registered read data.
  always @(posedge CLK) begin
    mem_rdata <= mem[mem_addr[7:0]];
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  always @(negedge CLK) begin
    if (mem_we) begin
      wcnt++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one request, return latency (accept edge counted as 1), the word
  // index seen right after accept, and the response fields.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] ma);
    check("req_ready_before_issue", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    ma  = mem_addr;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          w0;
    logic [31:0] ma;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          w0;
    logic [31:0] ma;

    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err",   {31'h0, resp_err}, 32'h0);
    check("rst_mem_we",     {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr",   mem_addr, 32'h0);
    check("rst_ready_in_reset", {31'h0, req_ready}, 32'h0);
    RST = 1'b0;
    #1;
    check("rst_ready_after", {31'h0, req_ready}, 32'h1);

    // LW 0x14 -> word 5
    issue(1'b0, F3_W, 32'h14, 32'h0, lat, ma);
    check("lw14_mem_addr", ma, 32'd5);
    check("lw14_latency", 32'(lat), 32'd3);
    check("lw14_rdata", resp_rdata, 32'h5);
    check("lw14_err", {31'h0, resp_err}, 32'h0);
    @(posedge CLK); #1;
    check("lw14_pulse_drop", {31'h0, resp_valid}, 32'h0);
    check("lw14_rdata_hold", resp_rdata, 32'h5);

    // SB 0x0D: byte 1 of word 3 becomes 0x80
    w0 = wcnt;
    issue(1'b1, F3_B, 32'h0D, 32'h12345680, lat, ma);
    check("sb0d_latency", 32'(lat), 32'd4);
    check("sb0d_wcount", 32'(wcnt - w0), 32'd1);
    check("sb0d_waddr", last_wa, 32'd3);
    check("sb0d_wdata", last_wd, 32'h00008003);
    check("sb0d_rdata", resp_rdata, 32'h0);
    issue(1'b0, F3_W, 32'h0C, 32'h0, lat, ma);
    check("lw0c_rdata", resp_rdata, 32'h00008003);
    issue(1'b0, F3_B, 32'h0D, 32'h0, lat, ma);
    check("lb0d_rdata", resp_rdata, 32'hFFFFFF80);
    issue(1'b0, F3_BU, 32'h0D, 32'h0, lat, ma);
    check("lbu0d_rdata", resp_rdata, 32'h00000080);

    // Errors: misaligned SH, out-of-range LW, illegal load funct3
    w0 = wcnt;
    issue(1'b1, F3_H, 32'h21, 32'hFFFF, lat, ma);
    check("sh21_latency", 32'(lat), 32'd2);
    check("sh21_err", {31'h0, resp_err}, 32'h1);
    check("sh21_rdata", resp_rdata, 32'h0);
    issue(1'b0, F3_W, 32'h402, 32'h0, lat, ma);
    check("lw402_latency", 32'(lat), 32'd2);
    check("lw402_err", {31'h0, resp_err}, 32'h1);
    check("lw402_rdata", resp_rdata, 32'h0);
    issue(1'b0, 3'b011, 32'h8, 32'h0, lat, ma);
    check("ld011_err", {31'h0, resp_err}, 32'h1);
    check("err_no_write", 32'(wcnt - w0), 32'd0);

    // SW to the last word, then halfword reads of it
    w0 = wcnt;
    issue(1'b1, F3_W, 32'h3FC, 32'hDEADBEEF, lat, ma);
    check("sw3fc_latency", 32'(lat), 32'd2);
    check("sw3fc_err", {31'h0, resp_err}, 32'h0);
    check("sw3fc_wcount", 32'(wcnt - w0), 32'd1);
    check("sw3fc_waddr", last_wa, 32'd255);
    check("sw3fc_wdata", last_wd, 32'hDEADBEEF);
    issue(1'b0, F3_H, 32'h3FE, 32'h0, lat, ma);
    check("lh3fe_rdata", resp_rdata, 32'hFFFFDEAD);
    issue(1'b0, F3_HU, 32'h3FC, 32'h0, lat, ma);
    check("lhu3fc_rdata", resp_rdata, 32'h0000BEEF);

    // SB 0x10 abandoned by reset in the MRG cycle
    w0 = wcnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h10; req_wdata = 32'hAB;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rmw_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rmw_rst_resp_rdata", resp_rdata, 32'h0);
    check("rmw_rst_resp_err",   {31'h0, resp_err}, 32'h0);
    check("rmw_rst_mem_we",     {31'h0, mem_we}, 32'h0);
    check("rmw_rst_mem_addr",   mem_addr, 32'h0);
    check("rmw_rst_mem_wdata",  mem_wdata, 32'h0);
    RST = 1'b0;
    #1;
    check("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
    check("rmw_rst_no_write", 32'(wcnt - w0), 32'd0);
    issue(1'b0, F3_W, 32'h10, 32'h0, lat, ma);
    check("lw10_rdata", resp_rdata, 32'h4);

    // Back-to-back: second LW issued in the resp_valid cycle of the first
    issue(1'b0, F3_W, 32'h04, 32'h0, lat, ma);
    check("b2b_first_latency", 32'(lat), 32'd3);
    check("b2b_first_rdata", resp_rdata, 32'h1);
    check("b2b_first_valid", {31'h0, resp_valid}, 32'h1);
    issue(1'b0, F3_W, 32'h08, 32'h0, lat, ma);
    check("b2b_second_latency", 32'(lat), 32'd3);
    check("b2b_second_rdata", resp_rdata, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
